// File: rtl/div_ctrl.sv
// div_ctrl: sequencing controller between the EX stage and a multi-cycle DIV/DIVU unit
//   in : clk, rst (async, active-high), div_req/div_sign/op_a/op_b from EX,
//        flush, stall_mem from the pipeline, dv_busy/dv_result from the divider
//   out: dv_start/dv_sign/dv_a/dv_b to the divider, stall_div to the pipeline,
//        res_valid/hilo_we/hi_out/lo_out/dz result side, err sticky timeout
module div_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req,
  input  logic        div_sign,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  input  logic        stall_mem,
  input  logic        dv_busy,
  input  logic [63:0] dv_result,
  output logic        dv_start,
  output logic        dv_sign,
  output logic [31:0] dv_a,
  output logic [31:0] dv_b,
  output logic        stall_div,
  output logic        res_valid,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        dz,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DONE, DRAIN} state_t;
  // never time out before a nominal-length divide could have finished
  localparam int LIM = (TIMEOUT > DIV_CYCLES + 1) ? TIMEOUT : DIV_CYCLES + 2;
  localparam logic [7:0] LIM8 = 8'(LIM);
  state_t r_state, w_next;
  logic [7:0] r_cnt;
  logic r_start, r_sign, r_dz, r_err;
  logic [31:0] r_a, r_b, r_hi, r_lo;
  logic w_acc, w_cap, w_to;
  always_comb begin
    // a divider still busy from an aborted operation blocks acceptance
    w_acc = r_state == IDLE && div_req && !flush && !dv_busy;
    // r_cnt == 0 marks the first RUN cycle, where busy has not risen yet
    w_cap = r_state == RUN && !flush && r_cnt != 8'd0 && !dv_busy;
    w_to = r_state == RUN && !flush && !w_cap && r_cnt == LIM8 - 8'd1;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? LAUNCH : IDLE;
      LAUNCH:  w_next = flush ? DRAIN : RUN;
      RUN:     w_next = (flush || w_to) ? DRAIN : w_cap ? DONE : RUN;
      DONE:    w_next = (!stall_mem || flush) ? IDLE : DONE;
      DRAIN:   w_next = dv_busy ? DRAIN : IDLE;
      default: w_next = IDLE;
    endcase
    stall_div = r_state == LAUNCH || r_state == RUN ||
                ((r_state == IDLE || r_state == DRAIN) && div_req && !flush && !w_acc);
    res_valid = r_state == DONE;
    hilo_we = res_valid && !stall_mem && !flush;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_start <= 1'b0;
      r_sign <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_dz <= 1'b0;
      r_cnt <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_acc;
      if (w_acc) begin
        r_a <= op_a;
        r_b <= op_b;
        r_sign <= div_sign;
        r_dz <= op_b == 32'd0;
      end
      if (r_state == LAUNCH) r_cnt <= '0;
      else if (r_state == RUN) r_cnt <= r_cnt + 8'd1;
      if (w_cap) {r_hi, r_lo} <= dv_result;
      if (w_to) r_err <= 1'b1;
    end
  end
  assign dv_start = r_start;
  assign dv_sign = r_sign;
  assign dv_a = r_a;
  assign dv_b = r_b;
  assign hi_out = r_hi;
  assign lo_out = r_lo;
  assign dz = r_dz;
  assign err = r_err;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed and random checks of div_ctrl against a behavioural divider and timeline model
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic div_req = 1'b0, div_sign = 1'b0, flush = 1'b0, stall_mem = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic dv_busy;
  logic [63:0] dv_result;
  logic dv_start, dv_sign, stall_div, res_valid, hilo_we, dz, err;
  logic [31:0] dv_a, dv_b, hi_out, lo_out;
  int tests = 0, fails = 0;
  int bcnt = 0;
  logic stuck = 1'b0;
  logic [63:0] dres = '0;

  div_ctrl dut (
    .clk(clk), .rst(rst), .div_req(div_req), .div_sign(div_sign), .op_a(op_a), .op_b(op_b),
    .flush(flush), .stall_mem(stall_mem), .dv_busy(dv_busy), .dv_result(dv_result),
    .dv_start(dv_start), .dv_sign(dv_sign), .dv_a(dv_a), .dv_b(dv_b), .stall_div(stall_div),
    .res_valid(res_valid), .hilo_we(hilo_we), .hi_out(hi_out), .lo_out(lo_out), .dz(dz), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin q = '1; r = a; end
    else if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) begin q = a; r = '0; end
    else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
    else begin q = a / b; r = a % b; end
    return {r, q};
  endfunction

  // divider: busy for 32 cycles starting the cycle after start
  always @(posedge clk) begin
    if (dv_start) begin
      bcnt <= 32;
      dres <= ref_div(dv_a, dv_b, dv_sign);
    end else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign dv_busy = bcnt != 0 || stuck;
  assign dv_result = dres;

  task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", t, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int nst);
    logic [63:0] e;
    int nstall, bad;
    e = ref_div(a, b, s);
    nstall = 0;
    bad = 0;
    cyc(); div_req = 1; op_a = a; op_b = b; div_sign = s;
    smp(); chk("acc_stall", stall_div, 0); chk("acc_start", dv_start, 0);
    cyc(); div_req = 0; op_a = $urandom; op_b = $urandom; div_sign = 1'($urandom);
    smp();
    chk("launch_start", dv_start, 1); chk("launch_stall", stall_div, 1);
    chk("launch_a", dv_a, a); chk("launch_b", dv_b, b); chk("launch_sign", dv_sign, s);
    chk("launch_dz", dz, b == 0);
    for (int i = 2; i <= 34; i++) begin
      cyc(); smp();
      nstall += int'(stall_div);
      bad += int'(dv_start | res_valid | hilo_we);
      if (dv_a !== a || dv_b !== b || dv_sign !== s) bad++;
    end
    chk("run_stall_cycles", nstall, 33); chk("run_unexpected", bad, 0);
    for (int i = 0; i < nst; i++) begin
      cyc(); stall_mem = 1; smp();
      chk("hold_valid", res_valid, 1); chk("hold_we", hilo_we, 0); chk("hold_stall", stall_div, 0);
      chk("hold_hilo", {hi_out, lo_out}, e);
    end
    cyc(); stall_mem = 0; smp();
    chk("done_valid", res_valid, 1); chk("done_we", hilo_we, 1); chk("done_stall", stall_div, 0);
    chk("done_hi", hi_out, e[63:32]); chk("done_lo", lo_out, e[31:0]); chk("done_dz", dz, b == 0);
    cyc(); smp();
    chk("idle_valid", res_valid, 0); chk("idle_we", hilo_we, 0);
  endtask

  task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] e;
    int n, st;
    e = ref_div(a, b, s);
    n = 0;
    st = 0;
    cyc(); div_req = 0; smp();
    while (!res_valid && n < 60) begin
      st += int'(dv_start);
      cyc(); smp();
      n++;
    end
    chk("wr_valid", res_valid, 1); chk("wr_restart", st, 0); chk("wr_we", hilo_we, 1);
    chk("wr_hi", hi_out, e[63:32]); chk("wr_lo", lo_out, e[31:0]);
    cyc(); smp();
  endtask

  initial begin
    int n, ns, nb, we;
    #1 rst = 1;
    #2;
    chk("rst_start", dv_start, 0); chk("rst_stall", stall_div, 0); chk("rst_valid", res_valid, 0);
    chk("rst_we", hilo_we, 0); chk("rst_dz", dz, 0); chk("rst_err", err, 0);
    chk("rst_a", dv_a, 0); chk("rst_b", dv_b, 0); chk("rst_sign", dv_sign, 0);
    chk("rst_hilo", {hi_out, lo_out}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    do_op(32'd100, 32'd7, 1'b0, 0);
    chk("divu_lo", lo_out, 32'd14); chk("divu_hi", hi_out, 32'd2);
    do_op(32'hFFFFFFF9, 32'd2, 1'b1, 0);
    chk("div_lo", lo_out, 32'hFFFFFFFD); chk("div_hi", hi_out, 32'hFFFFFFFF); chk("div_dz", dz, 0);
    do_op(32'd555, 32'd9, 1'b0, 3);
    do_op(32'd1234, 32'd0, 1'b0, 0);
    chk("dz_flag", dz, 1);
    for (int k = 0; k < 8; k++) do_op($urandom, (k == 3) ? 32'd0 : $urandom, 1'($urandom), int'($urandom_range(0, 2)));

    // flush in RUN, then a request that must wait out the draining divider
    we = 0;
    cyc(); div_req = 1; op_a = 32'd200; op_b = 32'd3; div_sign = 0; smp();
    cyc(); div_req = 0; smp(); chk("fl_launch", dv_start, 1);
    for (int i = 2; i <= 9; i++) begin cyc(); smp(); we += int'(hilo_we); end
    cyc(); flush = 1; smp(); we += int'(hilo_we); chk("fl_valid", res_valid, 0);
    cyc(); flush = 0; smp(); chk("fl_stall", stall_div, 0); chk("fl_valid2", res_valid, 0);
    for (int i = 12; i <= 19; i++) begin cyc(); smp(); we += int'(hilo_we | res_valid); end
    cyc(); div_req = 1; op_a = 32'd50; op_b = 32'd5; div_sign = 0; smp();
    n = 0;
    ns = 0;
    while (!dv_start && n < 60) begin
      ns += int'(stall_div);
      we += int'(hilo_we);
      cyc(); smp();
      n++;
    end
    chk("fl_start_seen", dv_start, 1); chk("fl_wait", n, 16); chk("fl_stalls", ns, 15);
    chk("fl_no_we", we, 0);
    wait_result(32'd50, 32'd5, 1'b0);

    // flush and request together in IDLE: flush wins
    cyc(); div_req = 1; flush = 1; smp(); chk("fi_stall", stall_div, 0);
    cyc(); div_req = 0; flush = 0; smp(); chk("fi_start", dv_start, 0);
    cyc(); smp(); chk("fi_valid", res_valid, 0);

    // stuck busy: timeout after 40 RUN cycles
    cyc(); div_req = 1; op_a = 32'd9; op_b = 32'd4; smp();
    cyc(); div_req = 0; stuck = 1; smp(); chk("to_launch", dv_start, 1);
    n = 0;
    we = 0;
    while (!err && n < 100) begin
      cyc(); smp();
      we += int'(res_valid | hilo_we);
      n++;
    end
    chk("to_cycles", n, 41); chk("to_err", err, 1); chk("to_no_result", we, 0);
    chk("to_drain_stall", stall_div, 0);
    cyc(); div_req = 1; smp(); chk("to_refuse", stall_div, 1); chk("to_nostart", dv_start, 0);
    cyc(); stuck = 0; div_req = 0; smp();
    cyc(); smp(); chk("to_sticky", err, 1);

    // reset in the middle of RUN, then accept only after the divider goes idle
    cyc(); div_req = 1; op_a = 32'd77; op_b = 32'd6; div_sign = 1; smp();
    cyc(); div_req = 0; smp();
    repeat (4) begin cyc(); smp(); end
    chk("mr_pre_err", err, 1); chk("mr_pre_stall", stall_div, 1);
    #1 rst = 1;
    #1;
    chk("mr_stall", stall_div, 0); chk("mr_err", err, 0); chk("mr_a", dv_a, 0);
    chk("mr_b", dv_b, 0); chk("mr_sign", dv_sign, 0); chk("mr_hilo", {hi_out, lo_out}, 0);
    chk("mr_valid", res_valid, 0);
    cyc(); rst = 0; div_req = 1; op_a = 32'd81; op_b = 32'd9; div_sign = 0; smp();
    n = 0;
    ns = 0;
    nb = 0;
    while (!dv_start && n < 60) begin
      ns += int'(stall_div);
      nb += int'(dv_busy);
      cyc(); smp();
      n++;
    end
    chk("mr_start", dv_start, 1); chk("mr_stall_eq_busy", ns, nb); chk("mr_waited", nb > 20, 1);
    wait_result(32'd81, 32'd9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
